counter_incr_sched: RTL
=======================

# counter_incr_sched

Counter-increment scheduler for the AGC control-pulse datapath. It arbitrates the involuntary counter cells' up/down increment requests and grants one cell per memory cycle (MCT). For the granted cell it drives the counter address, INKL and a single PINC or MINC pulse into the crosspoint/control-pulse logic, then acknowledges the cell so its request flip-flop clears. It sits between the counter request latches and the crosspoint generator that consumes PINC/MINC/INKL.

## Interface
- NCELL, 20, number of counter cells; cell 0 is highest priority
- ADRW, 5, width of cell index on CADR
- CBASE, 'o24, counter address of cell 0; CADR = CBASE + index
- CLOCK  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- T05  in  1  one-CLOCK pulse, timing pulse 5 of the current MCT
- T12  in  1  one-CLOCK pulse, last timing pulse of the current MCT
- GOJAM  in  1  synchronous restart; abandons any grant
- INHINC  in  1  inhibit new grants (sampled at T12 only)
- UPRQ  in  NCELL  level up-count requests, held until ACK
- DNRQ  in  NCELL  level down-count requests, held until ACK
- INKL  out  1  increment MCT in progress
- PINC  out  1  one-CLOCK plus-increment pulse
- MINC  out  1  one-CLOCK minus-increment pulse
- CADR  out  ADRW+1  counter address of granted cell (0 when idle)
- ACK  out  NCELL  one-hot, one-CLOCK request-clear pulse

## Operation
- States: IDLE, EXEC. Registered winner index WIDX and direction WDIR (UP, DN, NONE).
- Candidate set at a T12 edge: cells with UPRQ|DNRQ, excluding the cell being acknowledged on that same edge.
- IDLE, T12, INHINC=0, GOJAM=0, candidate set non-empty: latch lowest-index candidate, WDIR = UP if only UPRQ, DN if only DNRQ, NONE if both. Go to EXEC.
- EXEC, T05: one-CLOCK pulse on PINC (UP) or MINC (DN). NONE produces no pulse (up and down cancel).
- EXEC, T12: one-CLOCK pulse on ACK[WIDX]. On the same edge, rearbitrate exactly as from IDLE: stay in EXEC with the new winner, or go to IDLE.
- INKL = 1 whenever the state is EXEC. CADR = CBASE + WIDX in EXEC, 0 in IDLE.
- Priority is fixed. No round-robin. Lower cells can starve; that is intended.
- GOJAM, on any edge: state goes to IDLE, WIDX/WDIR clear, and no ACK or PINC/MINC is issued on that edge. Pending requests remain and are served after GOJAM falls.
- A T05 pulse while IDLE has no effect. A T12 pulse with GOJAM high grants nothing.

## Timing
- Reset (rst low, async): state IDLE; INKL, PINC, MINC, CADR and ACK all 0.
- Requests are sampled only on T12 edges. A request that rises after T12 waits for the next T12, giving a 1-MCT minimum grant latency.
- Back-to-back service: INKL stays high continuously across an MCT boundary when a new winner is latched on the same T12 that acknowledges the old one.
- A requester must drop its request within one CLOCK of ACK. The masking rule prevents double service on the acknowledge edge.
- All outputs are registered. PINC/MINC assert the CLOCK after the T05 edge; ACK asserts the CLOCK after the T12 edge.
- rst low mid-EXEC: outputs clear immediately and no ACK follows; the request is served again later.

## Structure
- Shared package: the state enum (IDLE, EXEC), the direction enum (UP, DN, NONE), and the CBASE default constant.
- One sub-module, prio_enc_mask: a masked lowest-index-first priority encoder (NCELL in; valid and index out). The rest is a single FSM module.

## Test plan
- UPRQ[3]=1 before T12 → INKL rises the CLOCK after T12, CADR='o27; at T05 one PINC pulse; at next T12 ACK=1<<3; INKL falls.
- UPRQ[5] and DNRQ[2] both set → cell 2 first (MINC, CADR='o26), then cell 5 (PINC, CADR='o31); INKL stays high across the boundary and exactly two ACK pulses occur.
- UPRQ[7] and DNRQ[7] both set → INKL high for one MCT, CADR='o33, no PINC/MINC, ACK[7] pulses.
- INHINC=1 at T12 with DNRQ[0] set → no grant; INHINC=0 at the following T12 → grant proceeds normally.
- GOJAM pulse between T05 and T12 of a grant on cell 4 → INKL=0 the next CLOCK, no ACK; cell 4 re-granted at the first T12 after GOJAM falls.
- rst low during EXEC → all outputs 0 asynchronously; after release the pending request is granted at the next T12.

Source files
------------

// File: rtl/counter_incr_sched_pkg.sv
// Shared types and defaults for the AGC counter-increment scheduler.
package counter_incr_sched_pkg;

  localparam int NCELL_DEFAULT = 20;
  localparam int ADRW_DEFAULT  = 5;
  localparam int CBASE_DEFAULT = 'o24;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  // NONE is the cleared value so a GOJAM or reset leaves no pending direction.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } dir_e;

endpackage

// File: rtl/counter_incr_sched_if.sv
// Request/grant bundle between the counter request latches, the scheduler
// and the crosspoint generator.
interface counter_incr_sched_if #(
  parameter int NCELL = 20,
  parameter int ADRW  = 5
);
  logic             T05;
  logic             T12;
  logic             GOJAM;
  logic             INHINC;
  logic [NCELL-1:0] UPRQ;
  logic [NCELL-1:0] DNRQ;
  logic             INKL;
  logic             PINC;
  logic             MINC;
  logic [ADRW:0]    CADR;
  logic [NCELL-1:0] ACK;

  modport master (
    output T05, T12, GOJAM, INHINC, UPRQ, DNRQ,
    input  INKL, PINC, MINC, CADR, ACK
  );

  modport slave (
    input  T05, T12, GOJAM, INHINC, UPRQ, DNRQ,
    output INKL, PINC, MINC, CADR, ACK
  );
endinterface

// File: rtl/counter_incr_sched_prio_enc_mask.sv
// Masked priority encoder: the lowest-index request not blocked by the mask wins.
module prio_enc_mask #(
  parameter int NCELL = 20,
  parameter int IDXW  = 5
) (
  input  logic [NCELL-1:0] i_req,
  input  logic [NCELL-1:0] i_mask,
  output logic             o_valid,
  output logic [IDXW-1:0]  o_idx
);

  logic [NCELL-1:0] w_cand;

  assign w_cand  = i_req & ~i_mask;
  assign o_valid = |w_cand;

  // Scan downward so the last hit, and therefore the lowest index, wins.
  always_comb begin
    o_idx = '0;
    for (int i = NCELL - 1; i >= 0; i--) begin
      if (w_cand[i]) o_idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/counter_incr_sched.sv
// Grants one involuntary counter cell per MCT and drives INKL, CADR and a
// single PINC/MINC pulse for it, then acknowledges the cell at T12.
module counter_incr_sched
  import counter_incr_sched_pkg::*;
#(
  parameter int NCELL = NCELL_DEFAULT,
  parameter int ADRW  = ADRW_DEFAULT,
  parameter int CBASE = CBASE_DEFAULT
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  counter_incr_sched_if.slave  bus
);

  localparam int CW = ADRW + 1;

  state_e           r_state, w_state_nxt;
  logic [ADRW-1:0]  r_widx, w_widx_nxt;
  dir_e             r_wdir, w_wdir_nxt;
  logic             r_inkl, w_inkl_nxt;
  logic             r_pinc, w_pinc_nxt;
  logic             r_minc, w_minc_nxt;
  logic [CW-1:0]    r_cadr, w_cadr_nxt;
  logic [NCELL-1:0] r_ack, w_ack_nxt;

  logic [NCELL-1:0] w_req;
  logic [NCELL-1:0] w_cur_onehot;
  logic [NCELL-1:0] w_mask;
  logic             w_valid;
  logic [ADRW-1:0]  w_idx;
  dir_e             w_dir;
  logic             w_grant;

  assign w_req        = bus.UPRQ | bus.DNRQ;
  assign w_cur_onehot = NCELL'(1) << r_widx;
  // The cell acknowledged on this T12 still shows its request; keep it out
  // of the rearbitration so it is not served twice.
  assign w_mask       = (r_state == EXEC && bus.T12) ? w_cur_onehot : '0;

  prio_enc_mask #(
    .NCELL (NCELL),
    .IDXW  (ADRW)
  ) u_prio (
    .i_req   (w_req),
    .i_mask  (w_mask),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  always_comb begin
    unique case ({bus.UPRQ[w_idx], bus.DNRQ[w_idx]})
      2'b10:   w_dir = UP;
      2'b01:   w_dir = DN;
      default: w_dir = NONE;
    endcase
  end

  assign w_grant = bus.T12 && !bus.INHINC && w_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_widx_nxt  = r_widx;
    w_wdir_nxt  = r_wdir;
    w_pinc_nxt  = 1'b0;
    w_minc_nxt  = 1'b0;
    w_ack_nxt   = '0;
    if (bus.GOJAM) begin
      w_state_nxt = IDLE;
      w_widx_nxt  = '0;
      w_wdir_nxt  = NONE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            w_state_nxt = EXEC;
            w_widx_nxt  = w_idx;
            w_wdir_nxt  = w_dir;
          end
        end
        EXEC: begin
          if (bus.T05) begin
            w_pinc_nxt = (r_wdir == UP);
            w_minc_nxt = (r_wdir == DN);
          end
          if (bus.T12) begin
            w_ack_nxt = w_cur_onehot;
            if (w_grant) begin
              w_widx_nxt = w_idx;
              w_wdir_nxt = w_dir;
            end else begin
              w_state_nxt = IDLE;
              w_widx_nxt  = '0;
              w_wdir_nxt  = NONE;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_widx_nxt  = '0;
          w_wdir_nxt  = NONE;
        end
      endcase
    end
    w_inkl_nxt = (w_state_nxt == EXEC);
    w_cadr_nxt = w_inkl_nxt ? (CW'(CBASE) + CW'(w_widx_nxt)) : '0;
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_widx  <= '0;
      r_wdir  <= NONE;
      r_inkl  <= 1'b0;
      r_pinc  <= 1'b0;
      r_minc  <= 1'b0;
      r_cadr  <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_widx  <= w_widx_nxt;
      r_wdir  <= w_wdir_nxt;
      r_inkl  <= w_inkl_nxt;
      r_pinc  <= w_pinc_nxt;
      r_minc  <= w_minc_nxt;
      r_cadr  <= w_cadr_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign bus.INKL = r_inkl;
  assign bus.PINC = r_pinc;
  assign bus.MINC = r_minc;
  assign bus.CADR = r_cadr;
  assign bus.ACK  = r_ack;

endmodule
